// File: rtl/piezo_tone_engine_pkg.sv
// Shared types and the half-period rule for the PIEZO tone engine.
package piezo_pkg;

    localparam int unsigned HALF_W = 32;

    typedef logic [HALF_W-1:0] half_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENGINE,
        S_BEEP,
        S_GAP
    } state_t;

    // 0 Hz yields 0, which the divider treats as silence.
    function automatic half_t half_period(input half_t clk_hz, input half_t f_hz);
        half_t h;
        h = '0;
        if (f_hz != '0) begin
            h = clk_hz / (f_hz << 1);
            if (h == '0) h = half_t'(1);
        end
        return h;
    endfunction

endpackage

// File: rtl/piezo_tone_engine_if.sv
// Control and status bundle between the speed logic and the PIEZO tone engine.
interface piezo_tone_engine_if #(
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned DUR_W   = 16
);
    logic               engine_en;
    logic [LEVEL_W-1:0] speed_level;
    logic               beep_req;
    logic [15:0]        beep_freq_hz;
    logic [DUR_W-1:0]   beep_cycles;
    logic               beep_busy;
    logic               beep_done;
    logic               piezo;

    modport master (
        output engine_en, speed_level, beep_req, beep_freq_hz, beep_cycles,
        input  beep_busy, beep_done, piezo
    );

    modport slave (
        input  engine_en, speed_level, beep_req, beep_freq_hz, beep_cycles,
        output beep_busy, beep_done, piezo
    );
endinterface

// File: rtl/piezo_tone_engine_tone_divider.sv
// Square-wave generator: toggles wave every `half` clocks while run is high.
module tone_divider
    import piezo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  half_t half,
    input  logic  run,
    input  logic  clr,
    output logic  wave
);

    half_t cnt;

    // >= lets a shrinking half wrap immediately instead of running past it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (clr || !run || half == '0) begin
            cnt  <= '0;
            wave <= 1'b0;
        end else if (cnt >= half - half_t'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
        end else begin
            cnt <= cnt + half_t'(1);
        end
    end

endmodule

// File: rtl/piezo_tone_engine.sv
// Engine tone with pitch glide plus pre-emptive one-shot beeps on a single PIEZO pin.
module piezo_tone_engine
    import piezo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 10_000,
    parameter int unsigned BASE_TONE_HZ = 200,
    parameter int unsigned STEP_TONE_HZ = 150,
    parameter int unsigned LEVEL_W      = 4,
    parameter int unsigned GLIDE_DIV    = 50,
    parameter int unsigned GAP_CYCLES   = 20,
    parameter int unsigned DUR_W        = 16
) (
    input logic clk,
    input logic rst,
    piezo_tone_engine_if.slave bus
);

    localparam int unsigned TAB_N = 2 ** LEVEL_W;
    localparam half_t HALF0 = half_period(half_t'(CLK_FREQ_HZ), half_t'(BASE_TONE_HZ));

    half_t tgt_tab [TAB_N];

    for (genvar i = 0; i < TAB_N; i++) begin : g_tab
        assign tgt_tab[i] = half_period(half_t'(CLK_FREQ_HZ),
                                        half_t'(BASE_TONE_HZ + i * STEP_TONE_HZ));
    end

    state_t           state;
    state_t           state_next;
    half_t            phase_cnt;
    half_t            glide_cnt;
    half_t            cur_half;
    half_t            tgt;
    half_t            beep_half;
    logic [DUR_W-1:0] dur_q;
    logic             capture;
    logic             beep_last;
    logic             gap_last;
    logic             state_chg;
    logic             eng_wave;
    logic             beep_wave;

    assign tgt = tgt_tab[bus.speed_level];

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        beep_last  = (state == S_BEEP) && (phase_cnt == half_t'(dur_q) - half_t'(1));
        gap_last   = (state == S_GAP) && (phase_cnt == half_t'(GAP_CYCLES - 1));
        case (state)
            S_IDLE: begin
                if (bus.beep_req) begin
                    capture    = 1'b1;
                    state_next = S_BEEP;
                end else if (bus.engine_en) begin
                    state_next = S_ENGINE;
                end
            end
            S_ENGINE: begin
                if (bus.beep_req) begin
                    capture    = 1'b1;
                    state_next = S_BEEP;
                end else if (!bus.engine_en) begin
                    state_next = S_IDLE;
                end
            end
            S_BEEP: if (beep_last) state_next = S_GAP;
            S_GAP:  if (gap_last)  state_next = bus.engine_en ? S_ENGINE : S_IDLE;
            default: state_next = S_IDLE;
        endcase
        state_chg = (state_next != state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
        end else if (state_chg || !(state == S_BEEP || state == S_GAP)) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + half_t'(1);
        end
    end

    // Beep pitch is divided once here so the beep clocks see a stable half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dur_q     <= '0;
            beep_half <= '0;
        end else if (capture) begin
            dur_q     <= (bus.beep_cycles == '0) ? DUR_W'(1) : bus.beep_cycles;
            beep_half <= half_period(half_t'(CLK_FREQ_HZ), half_t'(bus.beep_freq_hz));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glide_cnt <= '0;
            cur_half  <= HALF0;
        end else if (glide_cnt == half_t'(GLIDE_DIV - 1)) begin
            glide_cnt <= '0;
            if (cur_half < tgt)      cur_half <= cur_half + half_t'(1);
            else if (cur_half > tgt) cur_half <= cur_half - half_t'(1);
        end else begin
            glide_cnt <= glide_cnt + half_t'(1);
        end
    end

    tone_divider u_engine_div (
        .clk  (clk),
        .rst  (rst),
        .half (cur_half),
        .run  (state == S_ENGINE),
        .clr  (state_chg),
        .wave (eng_wave)
    );

    tone_divider u_beep_div (
        .clk  (clk),
        .rst  (rst),
        .half (beep_half),
        .run  (state == S_BEEP),
        .clr  (state_chg),
        .wave (beep_wave)
    );

    assign bus.piezo     = eng_wave | beep_wave;
    assign bus.beep_busy = (state == S_BEEP) || (state == S_GAP);
    assign bus.beep_done = gap_last;

endmodule

// File: doc/piezo_tone_engine.md
Name: piezo_tone_engine

Overview:
Second-generation PIEZO driver. It produces a speed-dependent engine tone whose pitch glides toward its target instead of jumping. It also accepts one-shot beep requests (alerts, UI clicks) that pre-empt the engine tone and then hand back to it. The block sits between the vehicle-speed logic and the PIEZO pin and drives that single output.

Parameters:
CLK_FREQ_HZ, 10_000, input clock frequency in Hz
BASE_TONE_HZ, 200, engine tone at speed level 0
STEP_TONE_HZ, 150, engine tone increment per speed level
LEVEL_W, 4, width of speed_level
GLIDE_DIV, 50, clocks between successive 1-count steps of the engine half-period
GAP_CYCLES, 20, silent clocks inserted after every beep
DUR_W, 16, width of beep_cycles

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
engine_en  in  1  1 = engine tone audible; 0 = engine muted (glide keeps tracking)
speed_level  in  LEVEL_W  current speed step
beep_req  in  1  beep request, sampled each clock
beep_freq_hz  in  16  beep pitch in Hz; 0 = silent rest
beep_cycles  in  DUR_W  beep length in clocks; 0 treated as 1
beep_busy  out  1  beep or post-beep gap in progress
beep_done  out  1  one-clock pulse on the last GAP clock
piezo  out  1  square-wave output

Behaviour:
- Half-period rule: half(f) = CLK_FREQ_HZ / (2*f), integer truncation, clamped to a minimum of 1. If f = 0, the output is silent. All half-period arithmetic is 32-bit.
- Engine target: tgt = half(BASE_TONE_HZ + speed_level*STEP_TONE_HZ). Target values come from an elaboration-time table with 2^LEVEL_W entries; no runtime divider for the engine.
- Glide:
  - cur_half is a 32-bit register, reset to table[0].
  - A glide counter fires every GLIDE_DIV clocks. When it fires, cur_half moves 1 toward tgt; it holds when equal.
  - A speed_level change mid-glide simply retargets; there is no restart.
  - Glide runs in every state, including during beeps.
- FSM states: IDLE, ENGINE, BEEP, GAP. Reset state is IDLE.
  - IDLE: piezo held 0. Go to ENGINE when engine_en=1.
  - ENGINE: tone at cur_half. Go to IDLE when engine_en=0.
  - IDLE/ENGINE with beep_req=1:
    - Capture beep_freq_hz and beep_cycles.
    - Go to BEEP next clock; beep_busy=1 from that clock.
    - beep_req has priority over an engine_en change in the same clock.
  - BEEP:
    - Tone at half(beep_freq_hz), computed once at capture; this is the only runtime divide, and a multi-cycle or registered divider is allowed.
    - Lasts exactly max(beep_cycles,1) clocks, then goes to GAP.
    - beep_req is ignored while beep_busy=1; there is no queue.
  - GAP: piezo 0 for GAP_CYCLES clocks.
    - beep_done=1 on the final GAP clock.
    - Next state is ENGINE if engine_en=1, else IDLE. beep_busy drops on entry to that state.
- Tone counter:
  - In tone states, the tone counter counts 0..active_half-1. At terminal count it wraps to 0 and piezo toggles.
  - On any state change, the tone counter is cleared and piezo is forced to 0 in the same clock.
  - An active_half change without a state change (glide) takes effect at the next compare; there is no counter reset.
  - If the counter already exceeds a shrunken half, the compare is >= so it wraps immediately.
- Reset values: piezo=0, beep_busy=0, beep_done=0, state=IDLE, counters=0, cur_half=table[0].
- Reset asserted mid-beep aborts immediately. No beep_done is generated.

Decomposition:
- Package piezo_pkg holds:
  - the state enum
  - the half-period function used for table build
  - 32-bit width constants
- One sub-module, tone_divider: counter + toggle with inputs half, run, clr and output wave. Reuse it for both engine and beep.
- FSM, glide and capture live in the top level.

Test Plan:
- Reset, engine_en=1, speed_level=0 -> piezo toggles every 25 clocks (200 Hz); beep_busy=0.
- speed_level 0->4 (target 6) -> cur_half steps 25->6 one count per 50 clocks, reaching 6 after 950 clocks; piezo period shrinks monotonically.
- beep_req for 1 clock with beep_freq_hz=1000, beep_cycles=100:
  - piezo low at entry, then toggles every 5 clocks for 100 clocks
  - then 20 clocks low, beep_done pulse on the 20th
  - engine tone resumes with counter cleared
- Second beep_req while beep_busy=1 -> ignored; exactly one beep_done.
- Edge cases:
  - beep_freq_hz=0, beep_cycles=0 -> 1 silent BEEP clock, then GAP, then beep_done
  - engine_en=0 throughout -> returns to IDLE; piezo stays 0
- rst pulsed mid-BEEP -> all outputs 0 the same cycle, no beep_done; resumes from IDLE with cur_half=25.
